// File: rtl/encoder8to3_arb.sv
// Registered 8-to-3 priority encoder with request latching and a valid/ack handshake.
// Define ENC_ROTATE_PRIORITY_EN for round-robin priority; otherwise bit 7 always wins.
module encoder8to3_arb #(
    parameter bit EDGE_DETECT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic       multi,
    output logic [7:0] pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] req_d;
    logic [7:0] cap;
    logic [7:0] clr;
    logic [7:0] masked;
    logic [2:0] sel_idx;
    logic       sel_multi;
    logic       take_offer;
    logic       transfer;

    assign masked    = pending & mask;
    assign sel_multi = |(masked & (masked - 8'd1));
    assign transfer  = valid & ack;
    assign cap       = EDGE_DETECT ? (req & ~req_d) : req;
    assign clr       = transfer ? (8'h01 << code) : 8'h00;

`ifdef ENC_ROTATE_PRIORITY_EN
    logic [2:0] last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 3'd0;
        end else if (transfer) begin
            last_grant <= code;
        end
    end

    // Walk from lowest to highest priority so the last hit (L-1 first) sticks.
    always_comb begin
        sel_idx = 3'd0;
        for (int p = 7; p >= 0; p--) begin
            if (masked[last_grant - 3'd1 - 3'(p)]) begin
                sel_idx = last_grant - 3'd1 - 3'(p);
            end
        end
    end
`else
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (masked[i]) begin
                sel_idx = 3'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d   <= 8'h00;
            pending <= 8'h00;
        end else begin
            req_d   <= req;
            pending <= (pending & ~clr) | cap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_offer = 1'b0;
        case (state)
            IDLE: begin
                if (En && (|masked)) begin
                    take_offer = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Offer registers stay frozen for the whole OFFER state regardless of En/mask/req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code  <= 3'd0;
            multi <= 1'b0;
            valid <= 1'b0;
        end else if (take_offer) begin
            code  <= sel_idx;
            multi <= sel_multi;
            valid <= 1'b1;
        end else if (transfer) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encoder8to3_arb.sv
// Directed bench for encoder8to3_arb: a level-mode and an edge-mode instance share stimulus,
// expected codes go through a scoreboard queue and are popped when an offer is observed.
module tb_encoder8to3_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       En = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] mask = 8'h00;
    logic       ack = 1'b0;

    logic [2:0] code_l;
    logic       valid_l;
    logic       multi_l;
    logic [7:0] pending_l;
    logic [2:0] code_e;
    logic       valid_e;
    logic       multi_e;
    logic [7:0] pending_e;

    int total = 0;
    int passed = 0;
    int failed = 0;
    int exp_q[$];

    encoder8to3_arb #(.EDGE_DETECT(1'b0)) dut (
        .clk(clk), .rst(rst), .En(En), .req(req), .mask(mask), .ack(ack),
        .code(code_l), .valid(valid_l), .multi(multi_l), .pending(pending_l)
    );

    encoder8to3_arb #(.EDGE_DETECT(1'b1)) dut_e (
        .clk(clk), .rst(rst), .En(En), .req(req), .mask(mask), .ack(ack),
        .code(code_e), .valid(valid_e), .multi(multi_e), .pending(pending_e)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic en_v, input logic [7:0] req_v,
                                 input logic [7:0] mask_v, input logic ack_v);
        En   = en_v;
        req  = req_v;
        mask = mask_v;
        ack  = ack_v;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer is expected right now on the level instance; code comes from the scoreboard.
    task automatic expect_offer(input string tag, input logic exp_multi);
        int e;
        checkOutput({tag, "_valid"}, 8'(valid_l), 8'd1);
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            checkOutput({tag, "_code"}, 8'(code_l), 8'(e));
        end
        checkOutput({tag, "_multi"}, 8'(multi_l), 8'(exp_multi));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int seen;
        int budget;
        int e;

        // Reset values
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_pending", pending_l, 8'h00);
        checkOutput("rst_valid", 8'(valid_l), 8'd0);
        checkOutput("rst_code", 8'(code_l), 8'd0);
        checkOutput("rst_multi", 8'(multi_l), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Empty: nothing pending, nothing offered
        applyStimulus(1'b1, 8'h00, 8'hFF, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("empty_valid", 8'(valid_l), 8'd0);
            checkOutput("empty_pending", pending_l, 8'h00);
        end

        // Two requests in one pulse: 5 first with multi, then 2 alone
        applyStimulus(1'b1, 8'h24, 8'hFF, 1'b0);
        tick();
        checkOutput("p24_pending", pending_l, 8'h24);
        checkOutput("p24_novalid_yet", 8'(valid_l), 8'd0);
        req = 8'h00;
        exp_q.push_back(5);
        tick();
        expect_offer("p24_first", 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("p24_after_ack_pending", pending_l, 8'h04);
        checkOutput("p24_after_ack_valid", 8'(valid_l), 8'd0);
        exp_q.push_back(2);
        tick();
        expect_offer("p24_second", 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("p24_done_pending", pending_l, 8'h00);
        checkOutput("p24_done_valid", 8'(valid_l), 8'd0);

        // Mask hides bit 7; unmasking mid-offer must not change the held code
        applyStimulus(1'b1, 8'h81, 8'h7F, 1'b0);
        tick();
        checkOutput("p81_pending", pending_l, 8'h81);
        req = 8'h00;
        exp_q.push_back(0);
        tick();
        expect_offer("p81_masked", 1'b0);
        mask = 8'hFF;
        tick(2);
        checkOutput("p81_hold_valid", 8'(valid_l), 8'd1);
        checkOutput("p81_hold_code", 8'(code_l), 8'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("p81_ack_pending", pending_l, 8'h80);
        exp_q.push_back(7);
        tick();
        expect_offer("p81_next", 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("p81_done_pending", pending_l, 8'h00);

        // En=0 blocks offers but not capture; ack in IDLE is ignored
        applyStimulus(1'b0, 8'h10, 8'hFF, 1'b0);
        tick();
        checkOutput("en0_pending", pending_l, 8'h10);
        req = 8'h00;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("en0_idle_ack_pending", pending_l, 8'h10);
        checkOutput("en0_valid", 8'(valid_l), 8'd0);
        tick(3);
        checkOutput("en0_still_idle", 8'(valid_l), 8'd0);
        En = 1'b1;
        exp_q.push_back(4);
        tick();
        expect_offer("en1_offer", 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("en1_done_pending", pending_l, 8'h00);

        // Held req[3]: edge instance offers once, level instance re-offers after ack
        do_reset();
        applyStimulus(1'b1, 8'h08, 8'hFF, 1'b0);
        tick();
        checkOutput("hold_e_pending", pending_e, 8'h08);
        checkOutput("hold_l_pending", pending_l, 8'h08);
        exp_q.push_back(3);
        tick();
        expect_offer("hold_l_first", 1'b0);
        checkOutput("hold_e_valid", 8'(valid_e), 8'd1);
        checkOutput("hold_e_code", 8'(code_e), 8'd3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("hold_e_ack_pending", pending_e, 8'h00);
        checkOutput("hold_l_ack_pending", pending_l, 8'h08);
        checkOutput("hold_l_ack_valid", 8'(valid_l), 8'd0);
        exp_q.push_back(3);
        tick();
        expect_offer("hold_l_reoffer", 1'b0);
        checkOutput("hold_e_no_reoffer", 8'(valid_e), 8'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("hold_e_quiet_valid", 8'(valid_e), 8'd0);
            checkOutput("hold_e_quiet_pending", pending_e, 8'h00);
        end
        req = 8'h00;

        // Asynchronous reset in the middle of an offer
        do_reset();
        applyStimulus(1'b1, 8'h42, 8'hFF, 1'b0);
        tick();
        req = 8'h00;
        exp_q.push_back(6);
        tick();
        expect_offer("rst_mid_offer", 1'b1);
        checkOutput("rst_mid_pending_before", pending_l, 8'h42);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", 8'(valid_l), 8'd0);
        checkOutput("rst_mid_pending", pending_l, 8'h00);
        checkOutput("rst_mid_code", 8'(code_l), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // All requests held with continuous ack: priority order of successive grants
`ifdef ENC_ROTATE_PRIORITY_EN
        for (int k = 7; k >= 0; k--) exp_q.push_back(k);
        exp_q.push_back(7);
`else
        for (int k = 0; k < 9; k++) exp_q.push_back(7);
`endif
        applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        checkOutput("full_pending", pending_l, 8'hFF);
        seen = 0;
        budget = 40;
        while (exp_q.size() > 0 && budget > 0) begin
            tick();
            budget--;
            if (valid_l) begin
                e = exp_q.pop_front();
                checkOutput("full_seq_code", 8'(code_l), 8'(e));
                seen++;
            end
        end
        checkOutput("full_seq_count", 8'(seen), 8'd9);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        exp_q.delete();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
